// File: rtl/fib_datapath.sv
// Register/bus datapath for the Fibonacci control unit: R1..R3, DR1/DR2, AC, outr, two buses and an adder.
// Optional control-word checking is enabled by defining FIB_DATAPATH_BUS_CHECK_EN.
module fib_datapath #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_valid,
    output logic             init_ready,
    input  logic [WIDTH-1:0] init_r1,
    input  logic [WIDTH-1:0] init_r2,
    input  logic [2:0]       sel_A,
    input  logic             sel_B,
    input  logic             LD_R1,
    input  logic             LD_R2,
    input  logic             LD_R3,
    input  logic             LD_DR1,
    input  logic             LD_DR2,
    input  logic             LD_AC,
    input  logic             LD_outr,
    input  logic             sel_DR1,
    input  logic             sel_DR2,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf,
    output logic             err,
    output logic [WIDTH-1:0] bus1_mon
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] r1_reg, r2_reg, r3_reg;
    logic [WIDTH-1:0] dr1_reg, dr2_reg, ac_reg, outr_reg;
    logic             out_valid_reg, ovf_reg;

    logic [WIDTH-1:0] bus1, bus2;
    logic [WIDTH:0]   alu_sum;
    logic [WIDTH-1:0] bus1_src [8];
    logic             run;

    // Bus1 source table; unused codes 101..111 read as zero.
    assign bus1_src[0] = r1_reg;
    assign bus1_src[1] = r2_reg;
    assign bus1_src[2] = r3_reg;
    assign bus1_src[3] = ac_reg;
    assign bus1_src[4] = outr_reg;
    generate
        for (genvar gi = 5; gi < 8; gi++) begin : g_unused_src
            assign bus1_src[gi] = '0;
        end
    endgenerate

    assign bus1    = bus1_src[sel_A];
    assign bus2    = sel_B ? r2_reg : '0;
    assign alu_sum = {1'b0, dr1_reg} + {1'b0, dr2_reg};
    assign run     = (state_reg == RUN);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (init_valid) state_next = RUN;
            RUN:     if (LD_outr)    state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            r1_reg        <= '0;
            r2_reg        <= '0;
            r3_reg        <= '0;
            dr1_reg       <= '0;
            dr2_reg       <= '0;
            ac_reg        <= '0;
            outr_reg      <= '0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && init_valid) begin
                r1_reg  <= init_r1;
                r2_reg  <= init_r2;
                r3_reg  <= '0;
                dr1_reg <= '0;
                dr2_reg <= '0;
                ac_reg  <= '0;
                ovf_reg <= 1'b0;
            end else if (run) begin
                // All loads read pre-edge values, so register swaps are safe.
                if (LD_R1)  r1_reg  <= bus1;
                if (LD_R2)  r2_reg  <= bus1;
                if (LD_R3)  r3_reg  <= bus1;
                if (LD_DR1) dr1_reg <= sel_DR1 ? bus2 : bus1;
                if (LD_DR2) dr2_reg <= sel_DR2 ? bus1 : bus2;
                if (LD_AC) begin
                    ac_reg <= alu_sum[WIDTH-1:0];
                    if (alu_sum[WIDTH]) ovf_reg <= 1'b1;
                end
                if (LD_outr) begin
                    outr_reg      <= bus1;
                    out_valid_reg <= 1'b1;
                end
            end else if (state_reg == DONE && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

`ifdef FIB_DATAPATH_BUS_CHECK_EN
    logic err_reg;
    logic bad_sel_a, bad_sel_b, bad_hazard;

    assign bad_sel_a  = (sel_A > 3'd4) && (LD_R1 || LD_R2 || LD_R3 || LD_outr);
    assign bad_sel_b  = !sel_B && ((LD_DR1 && sel_DR1) || (LD_DR2 && !sel_DR2));
    assign bad_hazard = LD_AC && (LD_DR1 || LD_DR2);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (run && (bad_sel_a || bad_sel_b || bad_hazard)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign init_ready = (state_reg == IDLE);
    assign out_data   = outr_reg;
    assign out_valid  = out_valid_reg;
    assign ovf        = ovf_reg;
    assign bus1_mon   = bus1;

endmodule

// File: tb/tb_fib_datapath.sv
// Directed self-checking bench for fib_datapath; a 16-bit and an 8-bit instance run in lockstep.
module tb_fib_datapath;

`ifdef FIB_DATAPATH_BUS_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_valid = 1'b0;
    logic [15:0] init16_r1 = '0, init16_r2 = '0;
    logic [7:0]  init8_r1 = '0, init8_r2 = '0;
    logic [2:0]  sel_A = '0;
    logic        sel_B = 1'b1;
    logic        LD_R1 = 0, LD_R2 = 0, LD_R3 = 0, LD_DR1 = 0, LD_DR2 = 0, LD_AC = 0, LD_outr = 0;
    logic        sel_DR1 = 0, sel_DR2 = 0;
    logic        out_ready = 1'b0;

    logic        init_ready16, out_valid16, ovf16, err16;
    logic [15:0] out_data16, bus1_mon16;
    logic        init_ready8, out_valid8, ovf8, err8;
    logic [7:0]  out_data8, bus1_mon8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_datapath #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .init_valid(init_valid), .init_ready(init_ready16),
        .init_r1(init16_r1), .init_r2(init16_r2), .sel_A(sel_A), .sel_B(sel_B),
        .LD_R1(LD_R1), .LD_R2(LD_R2), .LD_R3(LD_R3), .LD_DR1(LD_DR1), .LD_DR2(LD_DR2),
        .LD_AC(LD_AC), .LD_outr(LD_outr), .sel_DR1(sel_DR1), .sel_DR2(sel_DR2),
        .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready),
        .ovf(ovf16), .err(err16), .bus1_mon(bus1_mon16)
    );

    fib_datapath #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .init_valid(init_valid), .init_ready(init_ready8),
        .init_r1(init8_r1), .init_r2(init8_r2), .sel_A(sel_A), .sel_B(sel_B),
        .LD_R1(LD_R1), .LD_R2(LD_R2), .LD_R3(LD_R3), .LD_DR1(LD_DR1), .LD_DR2(LD_DR2),
        .LD_AC(LD_AC), .LD_outr(LD_outr), .sel_DR1(sel_DR1), .sel_DR2(sel_DR2),
        .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready),
        .ovf(ovf8), .err(err8), .bus1_mon(bus1_mon8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        init_valid = 0; out_ready = 0;
        sel_A = 3'd0; sel_B = 1; sel_DR1 = 0; sel_DR2 = 0;
        LD_R1 = 0; LD_R2 = 0; LD_R3 = 0; LD_DR1 = 0; LD_DR2 = 0; LD_AC = 0; LD_outr = 0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] b);
        init16_r1 = a; init16_r2 = b;
        init8_r1 = a[7:0]; init8_r2 = b[7:0];
        init_valid = 1;
        tick();
        init_valid = 0;
    endtask

    task automatic step_t0();
        sel_A = 3'd0; sel_B = 1; LD_DR1 = 1; LD_DR2 = 1;
        tick();
        clear_ctrl();
    endtask

    task automatic step_t1();
        sel_A = 3'd1; LD_R1 = 1; LD_AC = 1;
        tick();
        clear_ctrl();
    endtask

    task automatic run_pass();
        step_t0();
        step_t1();
        sel_A = 3'd3; LD_R3 = 1; tick(); clear_ctrl();
        sel_A = 3'd2; LD_R2 = 1; tick(); clear_ctrl();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            init_valid = 1'($urandom); out_ready = 1'($urandom);
            sel_A = 3'($urandom); sel_B = 1'($urandom);
            sel_DR1 = 1'($urandom); sel_DR2 = 1'($urandom);
            {LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr} = 7'($urandom);
            init16_r1 = 16'($urandom); init16_r2 = 16'($urandom);
            init8_r1 = 8'($urandom); init8_r2 = 8'($urandom);
            tick();
        end
        clear_ctrl();
        rst = 0;
        checks++;
        if ({init_ready16, out_valid16, ovf16, err16} !== 4'b1000 ||
            {init_ready8, out_valid8, ovf8, err8} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: got16 rdy/val/ovf/err=%b%b%b%b got8=%b%b%b%b required 1000",
                     init_ready16, out_valid16, ovf16, err16, init_ready8, out_valid8, ovf8, err8);
        end
        checks++;
        if (out_data16 !== 16'd0 || out_data8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_out_data: got %0d/%0d required 0", out_data16, out_data8);
        end
        for (int s = 0; s < 5; s++) begin
            sel_A = 3'(s);
            #1;
            checks++;
            if (bus1_mon16 !== 16'd0 || bus1_mon8 !== 8'd0) begin
                errors++;
                $display("FAIL reset_reg sel_A=%0d: got %0d/%0d required 0", s, bus1_mon16, bus1_mon8);
            end
        end
        clear_ctrl();
        $display("reset: done");
    endtask

    task automatic test_fib_sequence();
        logic [15:0] exp_r3 [3];
        logic [15:0] exp_r1 [3];
        exp_r3 = '{16'd2, 16'd3, 16'd5};
        exp_r1 = '{16'd1, 16'd2, 16'd3};
        preload(16'd1, 16'd1);
        checks++;
        if (init_ready16 !== 1'b0) begin
            errors++;
            $display("FAIL run_init_ready: got %b required 0", init_ready16);
        end
        for (int p = 0; p < 3; p++) begin
            run_pass();
            sel_A = 3'd2; #1;
            checks++;
            if (bus1_mon16 !== exp_r3[p]) begin
                errors++;
                $display("FAIL pass%0d_r3: got %0d required %0d", p, bus1_mon16, exp_r3[p]);
            end
            sel_A = 3'd1; #1;
            checks++;
            if (bus1_mon16 !== exp_r3[p]) begin
                errors++;
                $display("FAIL pass%0d_r2: got %0d required %0d", p, bus1_mon16, exp_r3[p]);
            end
            sel_A = 3'd0; #1;
            checks++;
            if (bus1_mon16 !== exp_r1[p]) begin
                errors++;
                $display("FAIL pass%0d_r1: got %0d required %0d", p, bus1_mon16, exp_r1[p]);
            end
            $display("pass %0d: r3=%0d r1=%0d", p, exp_r3[p], exp_r1[p]);
        end
        sel_A = 3'd2; LD_outr = 1;
        tick();
        clear_ctrl();
        checks++;
        if (out_valid16 !== 1'b1 || out_data16 !== 16'd5) begin
            errors++;
            $display("FAIL end_step: got valid=%b data=%0d required valid=1 data=5", out_valid16, out_data16);
        end
        $display("end step: out_data=%0d", out_data16);
    endtask

    task automatic test_done_hold();
        logic [15:0] exp_reg [4];
        exp_reg = '{16'd3, 16'd5, 16'd5, 16'd5};
        for (int c = 0; c < 5; c++) begin
            out_ready = 0;
            init_valid = 1'(c);
            sel_A = 3'($urandom_range(0, 4));
            sel_DR1 = 1'($urandom); sel_DR2 = 1'($urandom);
            {LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr} = 7'($urandom) | 7'b0000001;
            tick();
            checks++;
            if (out_valid16 !== 1'b1 || out_data16 !== 16'd5 || init_ready16 !== 1'b0) begin
                errors++;
                $display("FAIL done_hold c%0d: got valid=%b data=%0d rdy=%b required 1/5/0",
                         c, out_valid16, out_data16, init_ready16);
            end
        end
        clear_ctrl();
        for (int s = 0; s < 4; s++) begin
            sel_A = 3'(s); #1;
            checks++;
            if (bus1_mon16 !== exp_reg[s]) begin
                errors++;
                $display("FAIL done_reg sel_A=%0d: got %0d required %0d", s, bus1_mon16, exp_reg[s]);
            end
        end
        clear_ctrl();
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++;
        if (out_valid16 !== 1'b0 || init_ready16 !== 1'b1 || out_data16 !== 16'd5) begin
            errors++;
            $display("FAIL done_release: got valid=%b rdy=%b data=%0d required 0/1/5",
                     out_valid16, init_ready16, out_data16);
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++;
        if (out_valid16 !== 1'b0 || init_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL idle_out_ready: got valid=%b rdy=%b required 0/1", out_valid16, init_ready16);
        end
        $display("done hold/release: done");
    endtask

    task automatic test_back_to_back();
        preload(16'd2, 16'd3);
        sel_A = 3'd1; LD_outr = 1;
        tick();
        for (int c = 0; c < 3; c++) begin
            sel_A = 3'd0;
            tick();
            checks++;
            if (out_data16 !== 16'd3 || out_valid16 !== 1'b1) begin
                errors++;
                $display("FAIL held_ld_outr c%0d: got data=%0d valid=%b required 3/1", c, out_data16, out_valid16);
            end
        end
        clear_ctrl();
        out_ready = 1;
        tick();
        clear_ctrl();
        checks++;
        if (out_valid16 !== 1'b0 || out_data16 !== 16'd3) begin
            errors++;
            $display("FAIL held_release: got valid=%b data=%0d required 0/3", out_valid16, out_data16);
        end
        $display("back to back ld_outr: out_data=%0d", out_data16);
    endtask

    task automatic test_overflow();
        preload(16'd200, 16'd100);
        step_t0();
        step_t1();
        sel_A = 3'd3; #1;
        checks++;
        if (bus1_mon8 !== 8'd44 || ovf8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf8: got ac=%0d ovf=%b required 44/1", bus1_mon8, ovf8);
        end
        checks++;
        if (bus1_mon16 !== 16'd300 || ovf16 !== 1'b0) begin
            errors++;
            $display("FAIL ovf16: got ac=%0d ovf=%b required 300/0", bus1_mon16, ovf16);
        end
        LD_outr = 1;
        tick();
        clear_ctrl();
        out_ready = 1;
        tick();
        clear_ctrl();
        checks++;
        if (ovf8 !== 1'b1 || init_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b rdy=%b required 1/1", ovf8, init_ready8);
        end
        preload(16'd1, 16'd1);
        checks++;
        if (ovf8 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b required 0", ovf8);
        end
        $display("overflow: ac8=44 ovf cleared by preload");
        LD_outr = 1;
        tick();
        clear_ctrl();
        out_ready = 1;
        tick();
        clear_ctrl();
    endtask

    task automatic test_reset_in_run();
        preload(16'd9, 16'd6);
        step_t0();
        step_t1();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (init_ready16 !== 1'b1 || out_valid16 !== 1'b0 || ovf16 !== 1'b0) begin
            errors++;
            $display("FAIL rst_run_flags: got rdy=%b valid=%b ovf=%b required 1/0/0", init_ready16, out_valid16, ovf16);
        end
        for (int s = 0; s < 5; s++) begin
            sel_A = 3'(s); #1;
            checks++;
            if (bus1_mon16 !== 16'd0) begin
                errors++;
                $display("FAIL rst_run_reg sel_A=%0d: got %0d required 0", s, bus1_mon16);
            end
        end
        clear_ctrl();
        preload(16'd3, 16'd4);
        run_pass();
        sel_A = 3'd2; #1;
        checks++;
        if (bus1_mon16 !== 16'd7 || bus1_mon8 !== 8'd7) begin
            errors++;
            $display("FAIL rst_run_r3: got %0d/%0d required 7", bus1_mon16, bus1_mon8);
        end
        clear_ctrl();
        $display("reset in run: r3=%0d", bus1_mon16);
    endtask

    task automatic test_bus_check();
        sel_A = 3'd6; LD_R1 = 1;
        tick();
        clear_ctrl();
        checks++;
        if (err16 !== EXP_ERR) begin
            errors++;
            $display("FAIL err_set: got %b required %b", err16, EXP_ERR);
        end
        sel_A = 3'd2; LD_outr = 1;
        tick();
        clear_ctrl();
        checks++;
        if (err16 !== EXP_ERR || out_valid16 !== 1'b1) begin
            errors++;
            $display("FAIL err_done: got err=%b valid=%b required %b/1", err16, out_valid16, EXP_ERR);
        end
        out_ready = 1;
        tick();
        clear_ctrl();
        checks++;
        if (err16 !== EXP_ERR || init_ready16 !== 1'b1) begin
            errors++;
            $display("FAIL err_idle: got err=%b rdy=%b required %b/1", err16, init_ready16, EXP_ERR);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (err16 !== 1'b0 || err8 !== 1'b0) begin
            errors++;
            $display("FAIL err_rst: got %b/%b required 0", err16, err8);
        end
        $display("bus check: err expected %b", EXP_ERR);
    endtask

    initial begin
        test_reset();
        test_fib_sequence();
        test_done_hold();
        test_back_to_back();
        test_overflow();
        test_reset_in_run();
        test_bus_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fib_datapath.md
Name: fib_datapath

Overview:
- Register/bus datapath that executes the per-step control word issued by the control unit.
- Holds R1, R2, R3, DR1, DR2, AC and outr, plus two buses and an adder ALU (AC <= DR1 + DR2).
- Adds an init handshake to preload R1/R2 and a result handshake to hand outr downstream.
- Run by the control unit's T0..T3 loop, it computes a Fibonacci-style sequence; outr captures R3 on the end step.

Parameters:
- WIDTH, 16, data width of every register, bus and ALU path.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- init_valid  input  1  preload request.
- init_ready  output  1  datapath can accept a preload.
- init_r1  input  WIDTH  preload value for R1.
- init_r2  input  WIDTH  preload value for R2.
- sel_A  input  3  bus1 driver: 000 R1, 001 R2, 010 R3, 011 AC, 100 outr.
- sel_B  input  1  bus2 driver: 1 = R2, 0 = bus2 is zero.
- LD_R1, LD_R2, LD_R3, LD_DR1, LD_DR2, LD_AC, LD_outr  input  1 each  register load enables.
- sel_DR1  input  1  DR1 source: 0 = bus1, 1 = bus2.
- sel_DR2  input  1  DR2 source: 0 = bus2, 1 = bus1.
- out_data  output  WIDTH  outr contents.
- out_valid  output  1  out_data holds a fresh result.
- out_ready  input  1  downstream accepts the result.
- ovf  output  1  sticky ALU carry-out flag.
- err  output  1  sticky control-word error flag (see Optional Feature).
- bus1_mon  output  WIDTH  current bus1 value, combinational, for debug.

Behaviour:
- Interface decisions: one clock, clk; reset rst is synchronous and active-high.
- Reset: all registers 0; FSM to IDLE; init_ready=1, out_valid=0, ovf=0, err=0, out_data=0. Reset wins over every other input in the same cycle.
- Bus1 mux: sel_A codes 101..111 drive 0.
- R1, R2, R3 and outr load bus1. DR1 and DR2 load per sel_DR1 / sel_DR2. AC loads the ALU result.
- ALU: sum = DR1 + DR2 at WIDTH+1 bits. AC gets the low WIDTH bits (wrap-around). When LD_AC is high and the carry bit is 1, ovf sets.
- All loads take effect on the clk edge where they are sampled, so a load is visible the next cycle. Reads use pre-edge values, so R1<=R2 and R2<=R3 in one cycle swap cleanly.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - init_ready=1; all LD_* ignored.
  - On init_valid: R1<=init_r1, R2<=init_r2, R3/DR1/DR2/AC<=0, ovf<=0; go to RUN.
- RUN:
  - init_ready=0; LD_* honoured.
  - If LD_outr=1: outr<=bus1, out_valid<=1, go to DONE. Other LD_* in that cycle are still honoured.
- DONE:
  - init_ready=0; all LD_* ignored; out_valid=1 and out_data held stable.
  - On out_ready: out_valid<=0, go to IDLE.
  - out_ready while out_valid=0 has no effect.
- init_valid outside IDLE is ignored and does not queue.
- LD_outr held high for several cycles produces exactly one result; repeats while in DONE are ignored.
- Registers keep their values across DONE -> IDLE, except as overwritten by the next preload.

Optional Feature:
- Macro: FIB_DATAPATH_BUS_CHECK_EN.
- With the macro: in RUN, err sets sticky when any of these occurs; only rst clears it:
  - sel_A is 101..111 while any of LD_R1/LD_R2/LD_R3/LD_outr is high;
  - sel_B=0 while a DR load selects bus2;
  - LD_AC=1 in the same cycle as LD_DR1 or LD_DR2 (stale-operand hazard).
- Without the macro: err is tied to 0 and no check logic is generated.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> all registers 0, init_ready=1, out_valid=0, ovf=0, err=0.
- Preload R1=1, R2=1, then three T0..T3 passes (T0: sel_A=000, sel_B=1, LD_DR1, LD_DR2; T1: sel_A=001, LD_R1, LD_AC; T2: sel_A=011, LD_R3; T3: sel_A=010, LD_R2) -> after each pass R3/R2 = 2, 3, 5 and R1 = 1, 2, 3. Then an end step (sel_A=010, LD_outr) -> out_valid=1, out_data=5.
- In DONE, hold out_ready=0 for 5 cycles while toggling LD_* and init_valid -> out_data stays 5 and no register changes. Then out_ready=1 -> out_valid=0 next cycle and init_ready=1.
- WIDTH=8, preload R1=200, R2=100, run T0 and T1 -> AC=44, ovf=1. Then preload R1=1, R2=1 -> ovf=0.
- Assert rst during RUN after T1 -> next cycle all registers 0 and FSM in IDLE. A following preload of 3/4 and one pass -> R3=7.
- With FIB_DATAPATH_BUS_CHECK_EN: in RUN drive sel_A=110 with LD_R1=1 -> err=1 next cycle and stays 1 through DONE/IDLE until rst. Without the macro, the same stimulus leaves err=0.
